// File: rtl/fir_output_requantizer.sv
// rtl/fir_output_requantizer.sv - 64-bit FIR accumulator to 16-bit sample requantizer
// Decimates, rounds half-up by a fixed right shift, saturates, and counts clipped samples.
`timescale 1ns/1ps
module fir_output_requantizer #(
   parameter int DATA_IN_WIDTH  = 64,
   parameter int DATA_OUT_WIDTH = 16,
   parameter int SHIFT          = 31,
   parameter int DECIM          = 1,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             clear,
   input  logic                             in_valid,
   input  logic signed [DATA_IN_WIDTH-1:0]  data_in,
   output logic                             out_valid,
   output logic signed [DATA_OUT_WIDTH-1:0] data_out,
   output logic                             sat_flag,
   output logic [CNT_WIDTH-1:0]             sat_count
);

   localparam int SUM_W = DATA_IN_WIDTH + 1;
   localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
   // Half an output LSB; collapses to zero when SHIFT is zero.
   localparam logic [SUM_W-1:0] RND     = (SUM_W'(1) << SHIFT) >> 1;
   localparam logic [PH_W-1:0]  PH_LAST = PH_W'(DECIM - 1);

   logic [PH_W-1:0]                phase;
   logic                           keep;
   logic signed [SUM_W-1:0]        sum;
   logic signed [SUM_W-1:0]        scaled;
   logic                           s1_valid;
   logic signed [SUM_W-1:0]        s1_data;
   logic                           fits;
   logic signed [DATA_OUT_WIDTH-1:0] sat_val;

   assign keep   = in_valid && !clear && (phase == '0);
   assign sum    = {data_in[DATA_IN_WIDTH-1], data_in} + RND;
   assign scaled = sum >>> SHIFT;

   // In range when every bit from the output sign bit upward matches.
   assign fits = (&s1_data[SUM_W-1:DATA_OUT_WIDTH-1]) || !(|s1_data[SUM_W-1:DATA_OUT_WIDTH-1]);

   always_comb begin
      sat_val = s1_data[DATA_OUT_WIDTH-1:0];
      if (!fits) begin
         if (s1_data[SUM_W-1])
            sat_val = {1'b1, {(DATA_OUT_WIDTH-1){1'b0}}};
         else
            sat_val = {1'b0, {(DATA_OUT_WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase <= '0;
      end else if (clear) begin
         phase <= '0;
      end else if (in_valid) begin
         phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         out_valid <= 1'b0;
         data_out  <= '0;
         sat_flag  <= 1'b0;
         sat_count <= '0;
      end else if (clear) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         sat_flag  <= 1'b0;
         sat_count <= '0;
      end else begin
         s1_valid  <= keep;
         if (keep)
            s1_data <= scaled;
         out_valid <= s1_valid;
         if (s1_valid) begin
            data_out <= sat_val;
            if (!fits) begin
               sat_flag <= 1'b1;
               if (sat_count != '1)
                  sat_count <= sat_count + CNT_WIDTH'(1);
            end
         end
      end
   end

endmodule
